uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampling UART receiver with a ready/valid output register.
// Parity checking is compiled in when the macro UART_RX_PARITY_EN is defined;
// without it, frames carry no parity bit and RX_PARITY_ERR is tied low.
module uart_rx_core #(
  parameter int unsigned CLK_DIV    = 27,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 UART_RX,
  input  logic                 RX_READY,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 RX_FRAME_ERR,
  output logic                 RX_PARITY_ERR,
  output logic                 RX_OVERRUN
);

  localparam int unsigned DIV_W = 16;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  // Reject out-of-range parameters at elaboration.
  if (CLK_DIV == 0 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS == 0 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_core: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_sync;
  logic [DIV_W-1:0]     div, div_n;
  logic [3:0]           cnt, cnt_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, ferr_n, ovr_n;
  logic                 tick, mid, complete;
`ifdef UART_RX_PARITY_EN
  logic                 pbad, pbad_n, perr, perr_n;
`endif

  assign tick = (div == DIV_MAX);
  assign mid  = tick && (cnt == 4'd15);

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state, counter, shift and output-register logic.
  always_comb begin
    state_n  = state;
    div_n    = div;
    cnt_n    = cnt;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    data_n   = RX_DATA;
    valid_n  = RX_VALID;
    ferr_n   = 1'b0;
    ovr_n    = 1'b0;
    complete = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_n   = pbad;
    perr_n   = 1'b0;
`endif
    if (RX_VALID && RX_READY) valid_n = 1'b0;
    if (state != IDLE) begin
      div_n = tick ? '0 : div + DIV_W'(1);
      if (tick) cnt_n = cnt + 4'd1;
    end
    case (state)
      IDLE: begin
        div_n = '0;
        cnt_n = '0;
        bit_n = '0;
`ifdef UART_RX_PARITY_EN
        pbad_n = 1'b0;
`endif
        if (!rx_sync) state_n = START;
      end
      START: begin
        if (tick && cnt == 4'd7) begin
          if (!rx_sync) begin
            state_n = DATA;
            div_n   = '0;
            cnt_n   = '0;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (mid) begin
          shreg_n = {rx_sync, shreg[DATA_BITS-1:1]};
          bit_n   = bit_cnt + 4'd1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid) begin
          if (rx_sync != ((^shreg) ^ 1'(PARITY_ODD))) begin
            perr_n = 1'b1;
            pbad_n = 1'b1;
          end
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (mid) begin
          if (!rx_sync) begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            complete = !pbad;
`else
            complete = 1'b1;
`endif
            state_n = IDLE;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end
      end
      BREAK: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (complete) begin
      if (RX_VALID && !RX_READY) begin
        ovr_n = 1'b1;
      end else begin
        data_n  = shreg;
        valid_n = 1'b1;
      end
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div          <= '0;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      RX_DATA      <= '0;
      RX_VALID     <= 1'b0;
      RX_FRAME_ERR <= 1'b0;
      RX_OVERRUN   <= 1'b0;
    end else begin
      div          <= div_n;
      cnt          <= cnt_n;
      bit_cnt      <= bit_n;
      shreg        <= shreg_n;
      RX_DATA      <= data_n;
      RX_VALID     <= valid_n;
      RX_FRAME_ERR <= ferr_n;
      RX_OVERRUN   <= ovr_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch flag for the frame in flight and its error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pbad <= 1'b0;
      perr <= 1'b0;
    end else begin
      pbad <= pbad_n;
      perr <= perr_n;
    end
  end
  assign RX_PARITY_ERR = perr;
`else
  assign RX_PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core (CLK_DIV=4, 8 data bits, 1 stop bit).
// Define UART_RX_PARITY_EN to also exercise the even-parity build.
module tb_uart_rx_core;

  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int HAS_PAR = 1;
`else
  localparam int HAS_PAR = 0;
`endif
  localparam int NBITS = 10 + HAS_PAR;
  // Line falls after edge 0; two sync flops plus the IDLE edge put START at edge 3,
  // the start mid-sample 8 ticks later, then one sample per bit time.
  localparam int COMPLETE_IDX = 3 + 8 * CLK_DIV + BIT_CLKS * (NBITS - 1);
  localparam int NEVER = 1 << 30;

  logic       clk;
  logic       reset;
  logic       UART_RX;
  logic       RX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_FRAME_ERR;
  logic       RX_PARITY_ERR;
  logic       RX_OVERRUN;

  int   n_checks;
  int   n_pass;
  int   cyc;
  int   fr_rise;
  int   fr_ferr;
  int   fr_perr;
  int   fr_ovr;
  logic prev_valid;

  uart_rx_core #(
    .CLK_DIV   (CLK_DIV),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .PARITY_ODD(0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .UART_RX      (UART_RX),
    .RX_READY     (RX_READY),
    .RX_DATA      (RX_DATA),
    .RX_VALID     (RX_VALID),
    .RX_FRAME_ERR (RX_FRAME_ERR),
    .RX_PARITY_ERR(RX_PARITY_ERR),
    .RX_OVERRUN   (RX_OVERRUN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_counters();
    cyc        = 0;
    fr_rise    = -1;
    fr_ferr    = 0;
    fr_perr    = 0;
    fr_ovr     = 0;
    prev_valid = RX_VALID;
  endtask

  // One clock; observe outputs just after the edge and tally events.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (RX_VALID && !prev_valid && fr_rise < 0) fr_rise = cyc;
    prev_valid = RX_VALID;
    fr_ferr += int'(RX_FRAME_ERR);
    fr_perr += int'(RX_PARITY_ERR);
    fr_ovr  += int'(RX_OVERRUN);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par,
                                             input logic stop_ok);
    logic [10:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
    b[9]   = (HAS_PAR != 0) ? par : stop_ok;
    b[10]  = stop_ok;
    return b;
  endfunction

  // Even parity bit: makes the total count of ones even.
  function automatic logic good_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_ok,
                            input int ready_from);
    logic [10:0] bits;
    bits = frame_bits(d, par, stop_ok);
    clear_counters();
    for (int n = 0; n < NBITS * BIT_CLKS; n++) begin
      UART_RX  = bits[n / BIT_CLKS];
      RX_READY = (n >= ready_from);
      step();
    end
  endtask

  task automatic hold_line(input logic val, input int cycles);
    UART_RX = val;
    clear_counters();
    repeat (cycles) step();
  endtask

  task automatic clear_valid();
    RX_READY = 1'b1;
    step();
    RX_READY = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    UART_RX  = 1'b1;
    RX_READY = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (RX_DATA !== 8'h00) $display("FAIL reset_data: got %h expected 00", RX_DATA); else n_pass++;
    n_checks++; if (RX_VALID !== 1'b0) $display("FAIL reset_valid: got %b expected 0", RX_VALID); else n_pass++;
    n_checks++; if ({RX_FRAME_ERR, RX_PARITY_ERR, RX_OVERRUN} !== 3'b000) $display("FAIL reset_pulses: got %b expected 000", {RX_FRAME_ERR, RX_PARITY_ERR, RX_OVERRUN}); else n_pass++;
    reset = 1'b1;
    hold_line(1'b1, 20);
    n_checks++; if (fr_rise !== -1 || fr_ferr !== 0 || fr_ovr !== 0) $display("FAIL idle_quiet: got rise %0d ferr %0d ovr %0d expected -1 0 0", fr_rise, fr_ferr, fr_ovr); else n_pass++;
  endtask

  task automatic test_basic();
    send_frame(8'hA5, good_par(8'hA5), 1'b1, NEVER);
    n_checks++; if (RX_DATA !== 8'hA5) $display("FAIL basic_data: got %h expected a5", RX_DATA); else n_pass++;
    n_checks++; if (fr_rise !== COMPLETE_IDX) $display("FAIL basic_latency: got %0d expected %0d", fr_rise, COMPLETE_IDX); else n_pass++;
    n_checks++; if (fr_ferr !== 0 || fr_perr !== 0 || fr_ovr !== 0) $display("FAIL basic_pulses: got ferr %0d perr %0d ovr %0d expected 0 0 0", fr_ferr, fr_perr, fr_ovr); else n_pass++;
    RX_READY = 1'b1;
    step();
    RX_READY = 1'b0;
    n_checks++; if (RX_VALID !== 1'b0) $display("FAIL basic_consume: got %b expected 0", RX_VALID); else n_pass++;
    n_checks++; if (RX_DATA !== 8'hA5) $display("FAIL basic_hold: got %h expected a5", RX_DATA); else n_pass++;
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, good_par(8'h3C), 1'b1, NEVER);
    n_checks++; if (RX_DATA !== 8'h3C || fr_rise !== COMPLETE_IDX) $display("FAIL ovr_first: got %h rise %0d expected 3c rise %0d", RX_DATA, fr_rise, COMPLETE_IDX); else n_pass++;
    send_frame(8'h81, good_par(8'h81), 1'b1, NEVER);
    n_checks++; if (fr_ovr !== 1) $display("FAIL ovr_pulse: got %0d expected 1", fr_ovr); else n_pass++;
    n_checks++; if (RX_DATA !== 8'h3C || RX_VALID !== 1'b1) $display("FAIL ovr_keep: got %h valid %b expected 3c valid 1", RX_DATA, RX_VALID); else n_pass++;
    // Ready rises exactly for the completion edge: new payload replaces old.
    send_frame(8'h81, good_par(8'h81), 1'b1, COMPLETE_IDX - 1);
    RX_READY = 1'b0;
    n_checks++; if (fr_ovr !== 0) $display("FAIL ovr_ready_none: got %0d expected 0", fr_ovr); else n_pass++;
    n_checks++; if (RX_DATA !== 8'h81) $display("FAIL ovr_ready_data: got %h expected 81", RX_DATA); else n_pass++;
    n_checks++; if (RX_VALID !== 1'b0) $display("FAIL ovr_ready_valid: got %b expected 0", RX_VALID); else n_pass++;
  endtask

  task automatic test_glitch();
    hold_line(1'b0, 20);
    UART_RX = 1'b1;
    repeat (100) step();
    n_checks++; if (fr_rise !== -1 || fr_ferr !== 0 || fr_perr !== 0 || fr_ovr !== 0) $display("FAIL glitch_quiet: got rise %0d ferr %0d perr %0d ovr %0d expected -1 0 0 0", fr_rise, fr_ferr, fr_perr, fr_ovr); else n_pass++;
    send_frame(8'h55, good_par(8'h55), 1'b1, NEVER);
    n_checks++; if (RX_DATA !== 8'h55 || fr_rise !== COMPLETE_IDX) $display("FAIL glitch_then_rx: got %h rise %0d expected 55 rise %0d", RX_DATA, fr_rise, COMPLETE_IDX); else n_pass++;
    clear_valid();
  endtask

  task automatic test_frame_err();
    send_frame(8'hFF, good_par(8'hFF), 1'b0, NEVER);
    n_checks++; if (fr_ferr !== 1) $display("FAIL ferr_pulse: got %0d expected 1", fr_ferr); else n_pass++;
    n_checks++; if (fr_rise !== -1 || RX_VALID !== 1'b0) $display("FAIL ferr_novalid: got rise %0d valid %b expected -1 0", fr_rise, RX_VALID); else n_pass++;
    n_checks++; if (RX_DATA !== 8'h55) $display("FAIL ferr_data_kept: got %h expected 55", RX_DATA); else n_pass++;
    hold_line(1'b0, 200);
    n_checks++; if (fr_ferr !== 0 || fr_rise !== -1) $display("FAIL break_quiet: got ferr %0d rise %0d expected 0 -1", fr_ferr, fr_rise); else n_pass++;
    hold_line(1'b1, 50);
    send_frame(8'h12, good_par(8'h12), 1'b1, NEVER);
    n_checks++; if (RX_DATA !== 8'h12 || fr_rise !== COMPLETE_IDX || fr_ferr !== 0) $display("FAIL ferr_recover: got %h rise %0d ferr %0d expected 12 rise %0d ferr 0", RX_DATA, fr_rise, fr_ferr, COMPLETE_IDX); else n_pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_valid();
    send_frame(8'h07, 1'b1, 1'b1, NEVER);
    n_checks++; if (RX_DATA !== 8'h07 || fr_rise !== COMPLETE_IDX || fr_perr !== 0) $display("FAIL parity_good: got %h rise %0d perr %0d expected 07 rise %0d perr 0", RX_DATA, fr_rise, fr_perr, COMPLETE_IDX); else n_pass++;
    clear_valid();
    send_frame(8'h07, 1'b0, 1'b1, NEVER);
    n_checks++; if (fr_perr !== 1) $display("FAIL parity_bad_pulse: got %0d expected 1", fr_perr); else n_pass++;
    n_checks++; if (fr_rise !== -1 || RX_VALID !== 1'b0 || fr_ferr !== 0) $display("FAIL parity_bad_drop: got rise %0d valid %b ferr %0d expected -1 0 0", fr_rise, RX_VALID, fr_ferr); else n_pass++;
    send_frame(8'h12, good_par(8'h12), 1'b1, NEVER);
  endtask
`endif

  task automatic test_reset_midframe();
    logic [10:0] bits;
    bits = frame_bits(8'hC3, good_par(8'hC3), 1'b1);
    clear_counters();
    for (int n = 0; n < 4 * BIT_CLKS + BIT_CLKS / 2; n++) begin
      UART_RX = bits[n / BIT_CLKS];
      step();
    end
    reset = 1'b0;
    #1;
    n_checks++; if (RX_DATA !== 8'h00 || RX_VALID !== 1'b0) $display("FAIL midrst_immediate: got %h valid %b expected 00 valid 0", RX_DATA, RX_VALID); else n_pass++;
    repeat (10) step();
    n_checks++; if ({RX_FRAME_ERR, RX_PARITY_ERR, RX_OVERRUN, RX_VALID} !== 4'b0000 || RX_DATA !== 8'h00) $display("FAIL midrst_held: got %b data %h expected 0000 data 00", {RX_FRAME_ERR, RX_PARITY_ERR, RX_OVERRUN, RX_VALID}, RX_DATA); else n_pass++;
    UART_RX = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    hold_line(1'b1, 20);
    n_checks++; if (fr_rise !== -1 || fr_ferr !== 0) $display("FAIL midrst_discard: got rise %0d ferr %0d expected -1 0", fr_rise, fr_ferr); else n_pass++;
    send_frame(8'h9A, good_par(8'h9A), 1'b1, NEVER);
    n_checks++; if (RX_DATA !== 8'h9A || fr_rise !== COMPLETE_IDX) $display("FAIL midrst_rx: got %h rise %0d expected 9a rise %0d", RX_DATA, fr_rise, COMPLETE_IDX); else n_pass++;
  endtask

  // Random payloads and ready policies against a transaction-level model.
  task automatic test_random();
    logic       mvalid;
    logic [7:0] mdata;
    logic [7:0] d;
    logic       r;
    logic       exp_ovr;
    logic [7:0] exp_data;
    int         exp_rise;
    int         gap;
    clear_valid();
    mvalid = 1'b0;
    mdata  = RX_DATA;
    for (int f = 0; f < 8; f++) begin
      d   = 8'($urandom);
      r   = 1'($urandom_range(0, 1));
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 80));
      if (gap > 0) hold_line(1'b1, gap);
      exp_ovr  = mvalid && !r;
      exp_data = exp_ovr ? mdata : d;
      exp_rise = exp_ovr ? -1 : COMPLETE_IDX;
      send_frame(d, good_par(d), 1'b1, r ? 0 : NEVER);
      RX_READY = 1'b0;
      n_checks++; if (RX_DATA !== exp_data) $display("FAIL rand_data[%0d]: got %h expected %h", f, RX_DATA, exp_data); else n_pass++;
      n_checks++; if (fr_ovr !== int'(exp_ovr)) $display("FAIL rand_ovr[%0d]: got %0d expected %0d", f, fr_ovr, exp_ovr); else n_pass++;
      n_checks++; if (fr_rise !== exp_rise) $display("FAIL rand_rise[%0d]: got %0d expected %0d", f, fr_rise, exp_rise); else n_pass++;
      n_checks++; if (RX_VALID !== !r || fr_ferr !== 0) $display("FAIL rand_valid[%0d]: got %b ferr %0d expected %b ferr 0", f, RX_VALID, fr_ferr, !r); else n_pass++;
      mvalid = !r;
      mdata  = exp_data;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_overrun();
    test_glitch();
    test_frame_err();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
